// File: rtl/seq_comparator_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: state encoding,
// counter sizing helper and the one-hot result encodings.
package seq_comparator_pkg;

  // State encoding (2-bit)
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } state_t;

  // Bit counter width: clog2(WIDTH), never below one bit.
  function automatic int cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

  // One-hot result as {a_grater, a_equal, a_lesser}
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

endpackage

// File: rtl/seq_comparator.sv
// Bit-serial unsigned magnitude comparator. Operands are captured on the
// accept edge and compared MSB-first, one bit per clock. With EARLY_EXIT the
// compare ends on the first differing bit; otherwise latency is always WIDTH.
module seq_comparator
  import seq_comparator_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic             a_grater,
  output logic             a_equal,
  output logic             a_lesser
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_decided;   // a difference has already been seen
  logic             r_dir_gt;    // direction of that first difference
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;

  logic w_a_msb;
  logic w_b_msb;
  logic w_diff;
  logic w_last;
  logic w_exit_early;
  logic w_accept;
  logic w_finish;
  logic w_dec;
  logic w_dir_gt;

  assign w_a_msb      = r_a[WIDTH-1];
  assign w_b_msb      = r_b[WIDTH-1];
  assign w_diff       = w_a_msb ^ w_b_msb;
  assign w_last       = (r_cnt == '0);
  assign w_exit_early = EARLY_EXIT && w_diff;
  assign w_accept     = (r_state == ST_IDLE) && start;
  assign w_finish     = (r_state == ST_SHIFT) && (w_last || w_exit_early);
  // Result as of this edge: an earlier sticky difference wins, else the
  // current bit pair decides (covers a difference found on the last bit).
  assign w_dec        = r_decided || w_diff;
  assign w_dir_gt     = r_decided ? r_dir_gt : w_a_msb;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start)    w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_finish) w_state_nxt = ST_DONE;
      ST_DONE:                w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture, shift/count, sticky difference and result flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_decided <= 1'b0;
      r_dir_gt  <= 1'b0;
      r_gt      <= 1'b0;
      r_eq      <= 1'b0;
      r_lt      <= 1'b0;
    end else if (w_accept) begin
      r_a       <= a;
      r_b       <= b;
      r_cnt     <= CW'(WIDTH-1);
      r_decided <= 1'b0;
      r_dir_gt  <= 1'b0;
      r_gt      <= 1'b0;
      r_eq      <= 1'b0;
      r_lt      <= 1'b0;
    end else if (r_state == ST_SHIFT) begin
      r_a   <= r_a << 1;
      r_b   <= r_b << 1;
      r_cnt <= r_cnt - CW'(1);
      if (!r_decided && w_diff) begin
        r_decided <= 1'b1;
        r_dir_gt  <= w_a_msb;
      end
      if (w_finish) begin
        if (w_dec) begin
          r_gt <= w_dir_gt;
          r_lt <= ~w_dir_gt;
          r_eq <= 1'b0;
        end else begin
          r_gt <= 1'b0;
          r_lt <= 1'b0;
          r_eq <= 1'b1;
        end
      end
    end
  end

  assign ready    = (r_state == ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign a_grater = r_gt;
  assign a_equal  = r_eq;
  assign a_lesser = r_lt;

  logic w_unused;
  assign w_unused = w_b_msb;

endmodule

// File: doc/seq_comparator.md
Name: seq_comparator

Overview:
Sequential, bit-serial magnitude comparator. It is the multi-cycle counterpart to the team's combinational 4-bit comparator. It accepts two unsigned WIDTH-bit operands through a start/ready handshake and compares them MSB-first, one bit per clock. It reports a one-hot greater/equal/lesser result with a single-cycle done pulse. Its target is area-constrained paths where a wide parallel compare is not affordable.

Parameters:
WIDTH, 4, operand width in bits (>=2)
EARLY_EXIT, 1, 1 = finish on the first differing bit; 0 = always take WIDTH cycles (constant latency)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, synchronous and active-low
start  input  1  request; accepted only when ready=1
a  input  WIDTH  operand A, unsigned, sampled on accept edge
b  input  WIDTH  operand B, unsigned, sampled on accept edge
ready  output  1  high only in IDLE
done  output  1  one-cycle pulse, result valid
a_grater  output  1  result: A > B
a_equal  output  1  result: A == B
a_lesser  output  1  result: A < B

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; done=0; a_grater=a_equal=a_lesser=0; internal regs cleared.
  - ready=1 in the first cycle after reset release.
- States:
  - IDLE: ready=1. On start=1, capture a,b into shift regs and bit counter=WIDTH-1; clear all three result flags; go to SHIFT.
  - SHIFT: ready=0. Each edge compares the current MSB of both shift regs, then shifts left and decrements the counter.
    - Bits differ and EARLY_EXIT=1: register a_grater=a_msb, a_lesser=b_msb; go to DONE.
    - Bits differ and EARLY_EXIT=0: latch the first difference in a sticky decided flag plus its direction; continue shifting.
    - Counter==0: register the final result (latched direction, or a_equal=1 if no difference); go to DONE.
  - DONE: done=1 for exactly this cycle; ready=0. Unconditionally go to IDLE on the next edge.
- Latency, with E0 = accept edge and cycles numbered after it:
  - EARLY_EXIT=1: done high in cycle k+1, where k = MSB-relative index of the first differing bit (0 = MSB). Equal operands give done in cycle WIDTH.
  - EARLY_EXIT=0: done high in cycle WIDTH always.
- Result flags:
  - Registered; exactly one is high from the done cycle onward.
  - Held through IDLE until the next accepted start, which clears them to 000.
- start while ready=0: ignored, not queued.
- start=1 in the done cycle: ignored; it is accepted on a later IDLE cycle.
- Back-to-back throughput: one compare per (latency+2) cycles.
- a and b are don't-care except on the accept edge; later changes have no effect.
- Reset mid-SHIFT or in DONE: abort immediately to IDLE; no done pulse; flags=000.
- Arithmetic is unsigned only; no X propagation requirement beyond reset.

Decomposition:
- Shared package holds:
  - the state encoding localparams (IDLE, SHIFT, DONE, 2-bit);
  - the counter width, computed as clog2(WIDTH);
  - a 3-bit result encoding constant set (GT=100, EQ=010, LT=001) for bench checking.
- No sub-module: the datapath is two shift regs, a counter and one bit compare; the block stays flat in a single module of roughly 150 RTL lines.

Test Plan:
1. WIDTH=4, EARLY_EXIT=1, a=1010 b=0010, start 1 cycle -> done in cycle 1, a_grater=1, others 0; ready returns in cycle 2.
2. EARLY_EXIT=1, a=1001 b=1000 -> done in cycle 4 (difference at LSB), a_grater=1. Then a=0101 b=1010 -> done in cycle 1, a_lesser=1.
3. a=0000 b=0000 -> done in cycle 4, a_equal=1. Flags stay 010 in IDLE until the next start, then clear to 000 on the accept edge.
4. EARLY_EXIT=0, a=1110 b=0001 -> done in cycle 4 (not 1), a_grater=1. Then a=0000 b=1000 -> done in cycle 4, a_lesser=1.
5. Start a=0110 b=0011. Pulse start again with a=0000 b=1111 during SHIFT and in the done cycle -> both ignored; result a_grater=1; a single done pulse.
6. Start a=0000 b=0000 (EARLY_EXIT=1); drive rst_n=0 at cycle 2 for one edge -> no done, flags=000, ready=1 the next cycle. A new compare a=0011 b=0100 -> done in cycle 2, a_lesser=1.
